// File: rtl/ibuffer_pkg.sv
// Shared configuration and entry type for the instruction buffer between IFU and decode.
package ibuffer_pkg;
  localparam int INSTR_PER_FETCH = 4;
  localparam int ILEN            = 32;
  localparam int PLEN            = 32;
  localparam int IBUF_DEPTH      = 16;
  localparam int DECODE_WIDTH    = 2;

  typedef struct packed {
    logic [PLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } ibuf_entry_t;
endpackage

// File: rtl/ibuffer_storage.sv
// Circular RAM with one write port per fetch slot and one read port per decode lane.
module ibuffer_storage
  import ibuffer_pkg::*;
#(
  parameter int IPF   = INSTR_PER_FETCH,
  parameter int IL    = ILEN,
  parameter int PL    = PLEN,
  parameter int DEPTH = IBUF_DEPTH,
  parameter int DW    = DECODE_WIDTH,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [PW-1:0]     wptr_i,
  input  logic [PL-1:0]     wpc_i,
  input  logic [IPF*IL-1:0] wdata_i,
  input  logic [PW-1:0]     rptr_i,
  output logic [DW*PL-1:0]  rd_pc_o,
  output logic [DW*IL-1:0]  rd_instr_o
);
  logic [PL+IL-1:0] mem [DEPTH];

  // Slot i lands at tail+i with its own PC; pointer arithmetic wraps at DEPTH.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < IPF; i++) begin
        mem[wptr_i + PW'(i)] <= {wpc_i + PL'(4 * i), wdata_i[i*IL +: IL]};
      end
    end
  end

  always_comb begin
    rd_pc_o    = '0;
    rd_instr_o = '0;
    for (int j = 0; j < DW; j++) begin
      rd_pc_o[j*PL +: PL]    = mem[rptr_i + PW'(j)][PL+IL-1:IL];
      rd_instr_o[j*IL +: IL] = mem[rptr_i + PW'(j)][IL-1:0];
    end
  end
endmodule

// File: rtl/ibuffer.sv
// Instruction buffer: accepts whole fetch groups, presents up to DECODE_WIDTH oldest instructions.
module ibuffer
  import ibuffer_pkg::*;
#(
  parameter int INSTR_PER_FETCH_P = INSTR_PER_FETCH,
  parameter int ILEN_P            = ILEN,
  parameter int PLEN_P            = PLEN,
  parameter int DEPTH             = IBUF_DEPTH,
  parameter int DECODE_WIDTH_P    = DECODE_WIDTH,
  localparam int PW               = $clog2(DEPTH),
  localparam int CW               = $clog2(DEPTH) + 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 ifu_ibuffer_rsp_valid_i,
  input  logic [PLEN_P-1:0]                    ifu_ibuffer_rsp_pc_i,
  input  logic [INSTR_PER_FETCH_P*ILEN_P-1:0]  ifu_ibuffer_rsp_data_i,
  output logic                                 ibuffer_ifu_rsp_ready_o,
  output logic [DECODE_WIDTH_P-1:0]            ibuffer_dec_valid_o,
  output logic [DECODE_WIDTH_P*PLEN_P-1:0]     ibuffer_dec_pc_o,
  output logic [DECODE_WIDTH_P*ILEN_P-1:0]     ibuffer_dec_instr_o,
  input  logic                                 dec_ibuffer_ready_i,
  input  logic                                 flush_i,
  output logic [CW-1:0]                        count_o
);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(DEPTH - INSTR_PER_FETCH_P);
  localparam logic [CW-1:0] GRP_CNT   = CW'(INSTR_PER_FETCH_P);
  localparam logic [CW-1:0] DW_CNT    = CW'(DECODE_WIDTH_P);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] n_lanes;
  logic          enq, deq;

  // Ready looks only at registered count so decode never reaches the IFU combinationally.
  assign ibuffer_ifu_rsp_ready_o = !rst && !flush_i && (count_q <= CNT_LIMIT);
  assign enq     = ifu_ibuffer_rsp_valid_i && ibuffer_ifu_rsp_ready_o;
  assign n_lanes = (count_q < DW_CNT) ? count_q : DW_CNT;
  assign deq     = dec_ibuffer_ready_i && !flush_i && (n_lanes != '0);
  assign count_o = count_q;

  always_comb begin
    ibuffer_dec_valid_o = '0;
    for (int j = 0; j < DECODE_WIDTH_P; j++) begin
      ibuffer_dec_valid_o[j] = (CW'(j) < n_lanes) && !flush_i;
    end
  end

  always_comb begin
    head_d  = head_q + (deq ? n_lanes[PW-1:0] : '0);
    tail_d  = tail_q + (enq ? GRP_CNT[PW-1:0] : '0);
    count_d = count_q + (enq ? GRP_CNT : '0) - (deq ? n_lanes : '0);
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  ibuffer_storage #(
    .IPF   (INSTR_PER_FETCH_P),
    .IL    (ILEN_P),
    .PL    (PLEN_P),
    .DEPTH (DEPTH),
    .DW    (DECODE_WIDTH_P)
  ) u_storage (
    .clk        (clk),
    .we_i       (enq),
    .wptr_i     (tail_q),
    .wpc_i      (ifu_ibuffer_rsp_pc_i),
    .wdata_i    (ifu_ibuffer_rsp_data_i),
    .rptr_i     (head_q),
    .rd_pc_o    (ibuffer_dec_pc_o),
    .rd_instr_o (ibuffer_dec_instr_o)
  );
endmodule

// File: tb/tb_ibuffer.sv
// Self-checking bench for ibuffer against a queue-based model of the instruction stream.
module tb_ibuffer;
  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in;
  logic [31:0]  pc_in;
  logic [127:0] data_in;
  logic         ready_o;
  logic [1:0]   valid_o;
  logic [63:0]  pc_o;
  logic [63:0]  instr_o;
  logic         dec_ready;
  logic         flush;
  logic [4:0]   count_o;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  ibuffer dut (
    .clk                     (clk),
    .rst                     (rst),
    .ifu_ibuffer_rsp_valid_i (valid_in),
    .ifu_ibuffer_rsp_pc_i    (pc_in),
    .ifu_ibuffer_rsp_data_i  (data_in),
    .ibuffer_ifu_rsp_ready_o (ready_o),
    .ibuffer_dec_valid_o     (valid_o),
    .ibuffer_dec_pc_o        (pc_o),
    .ibuffer_dec_instr_o     (instr_o),
    .dec_ibuffer_ready_i     (dec_ready),
    .flush_i                 (flush),
    .count_o                 (count_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare outputs mid-cycle against the model, then advance the model across the edge.
  task automatic step(output bit acc);
    int  n;
    bit  rdy;
    @(negedge clk);
    n   = (q.size() < 2) ? q.size() : 2;
    rdy = !flush && (16 - q.size() >= 4);
    chk("count", 64'(count_o), 64'(q.size()));
    chk("ready", 64'(ready_o), 64'(rdy));
    for (int j = 0; j < 2; j++) begin
      chk("valid", 64'(valid_o[j]), 64'((j < n) && !flush));
      if ((j < n) && !flush) begin
        chk("lane_pc", 64'(pc_o[j*32 +: 32]), 64'(q[j].pc));
        chk("lane_instr", 64'(instr_o[j*32 +: 32]), 64'(q[j].instr));
      end
    end
    acc = valid_in && rdy;
    if (flush) begin
      q.delete();
    end else begin
      if (dec_ready) repeat (n) void'(q.pop_front());
      if (acc) begin
        for (int i = 0; i < 4; i++) begin
          ent_t e;
          e.pc    = pc_in + 32'(4 * i);
          e.instr = data_in[i*32 +: 32];
          q.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_group();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    bit          acc;
    int          accepted;
    int          g;
    int          cyc;
    logic [31:0] base;

    rst       = 1'b1;
    valid_in  = 1'b0;
    pc_in     = '0;
    data_in   = '0;
    dec_ready = 1'b0;
    flush     = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic flow
    valid_in  = 1'b1;
    pc_in     = 32'h8000_0000;
    data_in   = {32'h193, 32'h113, 32'h93, 32'h13};
    dec_ready = 1'b1;
    step(acc);
    valid_in = 1'b0;
    chk("basic_pc0", 64'(pc_o[31:0]), 64'h8000_0000);
    chk("basic_instr1", 64'(instr_o[63:32]), 64'h93);
    chk("basic_count4", 64'(count_o), 64'd4);
    step(acc);
    chk("basic_pc2", 64'(pc_o[31:0]), 64'h8000_0008);
    chk("basic_pc3", 64'(pc_o[63:32]), 64'h8000_000C);
    step(acc);
    step(acc);
    chk("basic_empty", 64'(valid_o), 64'd0);

    // Fill: five groups offered with decode stalled, fifth waits for drain
    dec_ready = 1'b0;
    accepted  = 0;
    valid_in  = 1'b1;
    pc_in     = 32'h8000_0100;
    data_in   = rand_group();
    for (int k = 0; k < 6; k++) begin
      step(acc);
      if (acc) begin
        accepted++;
        pc_in   = pc_in + 32'h10;
        data_in = rand_group();
      end
    end
    chk("fill_accepted", 64'(accepted), 64'd4);
    chk("fill_count16", 64'(count_o), 64'd16);
    chk("fill_ready0", 64'(ready_o), 64'd0);
    dec_ready = 1'b1;
    cyc = 0;
    while (accepted < 5 && cyc < 20) begin
      step(acc);
      if (acc) accepted++;
      cyc++;
    end
    chk("fill_fifth_taken", 64'(accepted), 64'd5);
    valid_in = 1'b0;
    cyc = 0;
    while (q.size() != 0 && cyc < 40) begin
      step(acc);
      cyc++;
    end
    chk("fill_drained", 64'(q.size()), 64'd0);

    // Random traffic across pointer wrap and PC wrap
    base = 32'hFFFF_FFE0;
    g    = 0;
    cyc  = 0;
    pc_in   = base;
    data_in = rand_group();
    valid_in = 1'b0;
    while (g < 50 && cyc < 3000) begin
      if (!valid_in) valid_in = ($urandom_range(0, 1) == 1);
      dec_ready = ($urandom_range(0, 3) != 0);
      step(acc);
      if (acc) begin
        g++;
        pc_in    = base + 32'(g * 16);
        data_in  = rand_group();
        valid_in = ($urandom_range(0, 1) == 1);
      end
      cyc++;
    end
    chk("rand_groups_done", 64'(g), 64'd50);
    valid_in  = 1'b0;
    dec_ready = 1'b1;
    cyc = 0;
    while (q.size() != 0 && cyc < 40) begin
      step(acc);
      cyc++;
    end
    chk("rand_drained", 64'(count_o), 64'd0);

    // Flush with count 10 and a group offered
    dec_ready = 1'b0;
    valid_in  = 1'b1;
    pc_in     = 32'h8000_0200;
    for (int k = 0; k < 3; k++) begin
      data_in = rand_group();
      step(acc);
      pc_in = pc_in + 32'h10;
    end
    valid_in  = 1'b0;
    dec_ready = 1'b1;
    step(acc);
    chk("pre_flush_count", 64'(count_o), 64'd10);
    valid_in = 1'b1;
    flush    = 1'b1;
    step(acc);
    flush    = 1'b0;
    valid_in = 1'b0;
    chk("flush_count0", 64'(count_o), 64'd0);
    chk("flush_valid0", 64'(valid_o), 64'd0);
    valid_in = 1'b1;
    pc_in    = 32'h8000_1000;
    data_in  = rand_group();
    step(acc);
    valid_in  = 1'b0;
    dec_ready = 1'b0;
    chk("post_flush_pc", 64'(pc_o[31:0]), 64'h8000_1000);
    step(acc);

    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_count", 64'(count_o), 64'd0);
    chk("async_rst_valid", 64'(valid_o), 64'd0);
    chk("async_rst_ready", 64'(ready_o), 64'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(acc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ibuffer.md
Name: ibuffer

Overview:
- Instruction buffer sitting between the IFU and the decode stage.
- Accepts whole fetch groups (group PC plus INSTR_PER_FETCH instruction words) from the IFU over a valid/ready handshake.
- Stores each instruction with its own PC in a circular FIFO.
- Presents up to DECODE_WIDTH oldest instructions per cycle to decode.
- A backend flush empties it.

Parameters:
- INSTR_PER_FETCH, cfg.INSTR_PER_FETCH (4): instructions per fetch group.
- ILEN, cfg.ILEN (32): instruction width.
- PLEN, cfg.PLEN (32): PC width.
- DEPTH, 16: instruction entries; power of two, multiple of INSTR_PER_FETCH, at least 2*INSTR_PER_FETCH.
- DECODE_WIDTH, 2: decode lanes; 1 ≤ DECODE_WIDTH ≤ INSTR_PER_FETCH.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- ifu_ibuffer_rsp_valid_i  in  1  IFU has a fetch group.
- ifu_ibuffer_rsp_pc_i  in  PLEN  PC of fetch-group slot 0.
- ifu_ibuffer_rsp_data_i  in  INSTR_PER_FETCH*ILEN  instruction words, slot i = [i].
- ibuffer_ifu_rsp_ready_o  out  1  room for one full group.
- ibuffer_dec_valid_o  out  DECODE_WIDTH  per-lane valid, lane 0 oldest.
- ibuffer_dec_pc_o  out  DECODE_WIDTH*PLEN  per-lane PC.
- ibuffer_dec_instr_o  out  DECODE_WIDTH*ILEN  per-lane instruction.
- dec_ibuffer_ready_i  in  1  decode consumes all valid lanes this cycle.
- flush_i  in  1  backend flush, discard all contents.
- count_o  out  $clog2(DEPTH)+1  occupied entries (debug/perf).

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous and active-high (rst). While rst is high, head, tail and count are 0, ibuffer_dec_valid_o is 0 and ibuffer_ifu_rsp_ready_o is 0.
- State: head and tail pointers of width $clog2(DEPTH), plus count of width $clog2(DEPTH)+1. Storage is DEPTH entries of {pc, instr}. Pointers wrap modulo DEPTH; no explicit full/empty flag beyond count.
- Ready:
  - ready_o = !rst && !flush_i && (DEPTH - count ≥ INSTR_PER_FETCH).
  - Depends only on registered count, never on dec_ibuffer_ready_i, so there is no combinational path decode→IFU.
- Enqueue (enq = valid_i && ready_o):
  - Writes INSTR_PER_FETCH entries at tail+i (mod DEPTH).
  - Entry i gets instr = data_i[i] and pc = pc_i + 4*i, truncated to PLEN bits (wraps).
  - tail advances by INSTR_PER_FETCH.
  - Partial groups are never accepted.
- Dequeue:
  - Number of valid lanes n = min(count, DECODE_WIDTH), using the registered count.
  - Lane j ( j < n ) shows the entry at head+j. Lanes ≥ n have valid 0 and pc/instr don't-care.
  - ibuffer_dec_valid_o[j] = (j < n) && !flush_i.
  - When dec_ibuffer_ready_i && !flush_i, all n lanes are consumed and head advances by n. Decode cannot take a subset.
- Latency: a group enqueued at edge T is visible on the decode outputs from cycle T+1. There is no same-cycle bypass.
- Simultaneous enqueue and dequeue: count_next = count + (enq ? INSTR_PER_FETCH : 0) − (deq ? n : 0). Both pointers update in the same cycle.
- Full/empty:
  - count = 0: all lanes invalid; dec_ready is ignored.
  - free < INSTR_PER_FETCH: ready_o = 0; the IFU holds the group. Dequeue in that cycle only makes space visible from the next cycle.
- Flush (synchronous, highest priority after reset):
  - At the edge where flush_i = 1: head = tail = count = 0.
  - Any enqueue or dequeue offered in that cycle is discarded.
  - Decode valids and IFU ready are forced low during the flush cycle.
- Reset mid-operation: contents are lost immediately and asynchronously. Storage RAM is not cleared; only the pointers are.
- Ordering: program order is strictly preserved across groups and across wrap-around.

Decomposition:
- global_config_pkg (cfg) gains DECODE_WIDTH and IBUF_DEPTH.
- Add typedef ibuf_entry_t {logic [PLEN-1:0] pc; logic [ILEN-1:0] instr;} to the shared package.
- Natural sub-module: ibuffer_storage. It is the multi-port circular RAM with INSTR_PER_FETCH write ports and DECODE_WIDTH read ports, indexed by pointer+offset mod DEPTH.
- Control (pointers, count, handshakes) stays in ibuffer.

Test Plan (defaults INSTR_PER_FETCH=4, DEPTH=16, DECODE_WIDTH=2):
- Basic flow: after reset, enqueue one group, pc=0x80000000, data {0x13,0x93,0x113,0x193}, with dec_ready=1.
  - Cycle+1: lanes show pc 0x80000000/0x80000004, instr 0x13/0x93; count 4→2.
  - Cycle+2: pc 0x80000008/0x8000000C; then count 0 and valids 0.
- Fill: dec_ready=0, offer 5 groups back-to-back.
  - First 4 accepted; count=16 and ready_o=0.
  - 5th group held until dec_ready=1 drains to count ≤12. It is accepted the cycle after count shows 12.
- Simultaneous: count=12, enqueue and dequeue in the same cycle → count=14, and the group's PCs follow the existing ones in order.
- Odd tail: only count=1 left and dec_ready=1 → lane0 valid, lane1 invalid; count becomes 0.
- Wrap and scoreboard: 50 groups with random IFU valid and random decode stalls, PCs stepping by 0x10 from 0xFFFFFFE0.
  - Output stream matches the input order exactly across pointer wrap and the PC wrap to 0x00000000.
- Flush/reset: count=10 with enqueue valid and flush_i=1 → next cycle count=0, valids 0, group dropped.
  - A post-flush group at pc=0x80001000 is the first output.
  - Asserting rst between edges drops valids and count to 0 immediately.
